// File: rtl/licznik_czasu.sv
// licznik_czasu -- real-time clock time base and BCD hours/minutes counter.
//
// Divides clk_i down to a one-cycle tick per second. Seconds are kept
// internally in binary. Hours and minutes are kept as four BCD digits that
// feed the 7-segment multiplexer. A free-running refresh counter supplies
// that multiplexer's digit select. Two push buttons set the time. Each press
// produces exactly one increment; there is no debounce and no auto-repeat.
//
// Ports
//   clk_i          system clock; all state changes on the rising edge
//   rst_ni         asynchronous active-low reset (time 00:00:00)
//   set_min_i      minute-set button, asynchronous level, active high
//   set_hr_i       hour-set button, asynchronous level, active high
//   hr2_o/hr1_o    hours tens/units, BCD (00..23)
//   min2_o/min1_o  minutes tens/units, BCD (00..59)
//   odswiezanie_o  digit select: 00 hr2, 01 hr1, 10 min2, 11 min1
//   sec_tick_o     one-cycle pulse, once per second (registered tick)
module licznik_czasu #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned REFRESH_BITS = 18
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       set_min_i,
  input  logic       set_hr_i,
  output logic [3:0] hr2_o,
  output logic [3:0] hr1_o,
  output logic [3:0] min2_o,
  output logic [3:0] min1_o,
  output logic [1:0] odswiezanie_o,
  output logic       sec_tick_o
);

  localparam int unsigned PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0]           presc_q;
  logic [5:0]              sec_q;
  logic [REFRESH_BITS-1:0] refresh_q;
  // [0] first sync stage, [1] second sync stage, [2] edge-detect reference
  logic [2:0]              min_sync_q;
  logic [2:0]              hr_sync_q;

  logic tick;
  logic set_min_edge;
  logic set_hr_edge;
  logic min_carry;
  logic hr_carry;
  logic min_inc;
  logic hr_inc;

  assign tick         = (presc_q == PRESC_LAST);
  assign set_min_edge = min_sync_q[1] & ~min_sync_q[2];
  assign set_hr_edge  = hr_sync_q[1] & ~hr_sync_q[2];

  // A minute-set press takes priority over the seconds rollover. It clears
  // the seconds, so the carry from the rollover is dropped.
  assign min_carry = tick && (sec_q == 6'd59) && !set_min_edge;
  assign hr_carry  = min_carry && (min2_o == 4'd5) && (min1_o == 4'd9);

  // A press and a carry in the same cycle collapse into one increment.
  assign min_inc = set_min_edge | min_carry;
  assign hr_inc  = set_hr_edge | hr_carry;

  assign odswiezanie_o = refresh_q[REFRESH_BITS-1 -: 2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q    <= '0;
      sec_q      <= '0;
      refresh_q  <= '0;
      min_sync_q <= '0;
      hr_sync_q  <= '0;
      hr2_o      <= '0;
      hr1_o      <= '0;
      min2_o     <= '0;
      min1_o     <= '0;
      sec_tick_o <= 1'b0;
    end else begin
      min_sync_q <= {min_sync_q[1:0], set_min_i};
      hr_sync_q  <= {hr_sync_q[1:0], set_hr_i};
      refresh_q  <= refresh_q + REFRESH_BITS'(1);
      sec_tick_o <= tick;

      // Setting minutes restarts the current minute from :00.
      if (set_min_edge) begin
        presc_q <= '0;
        sec_q   <= '0;
      end else begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          sec_q <= (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        end
      end

      if (min_inc) begin
        if (min1_o == 4'd9) begin
          min1_o <= 4'd0;
          min2_o <= (min2_o == 4'd5) ? 4'd0 : min2_o + 4'd1;
        end else begin
          min1_o <= min1_o + 4'd1;
        end
      end

      // Check 23 first so the count goes straight to 00 and never shows 24.
      if (hr_inc) begin
        if (hr2_o == 4'd2 && hr1_o == 4'd3) begin
          hr2_o <= 4'd0;
          hr1_o <= 4'd0;
        end else if (hr1_o == 4'd9) begin
          hr1_o <= 4'd0;
          hr2_o <= hr2_o + 4'd1;
        end else begin
          hr1_o <= hr1_o + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_licznik_czasu.sv
module tb_licznik_czasu;

  localparam int unsigned CLK_HZ       = 4;
  localparam int unsigned REFRESH_BITS = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       set_min_i;
  logic       set_hr_i;
  logic [3:0] hr2_o, hr1_o, min2_o, min1_o;
  logic [1:0] odswiezanie_o;
  logic       sec_tick_o;

  int n_vec  = 0;
  int n_miss = 0;
  logic bad_seen = 1'b0;

  licznik_czasu #(.CLK_HZ(CLK_HZ), .REFRESH_BITS(REFRESH_BITS)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .set_min_i     (set_min_i),
    .set_hr_i      (set_hr_i),
    .hr2_o         (hr2_o),
    .hr1_o         (hr1_o),
    .min2_o        (min2_o),
    .min1_o        (min1_o),
    .odswiezanie_o (odswiezanie_o),
    .sec_tick_o    (sec_tick_o)
  );

  always #5 clk_i = ~clk_i;

  // Flags any displayed time outside 00:00..23:59, such as a pass through 24:00.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (hr2_o > 4'd2 || hr1_o > 4'd9 || (hr2_o == 4'd2 && hr1_o > 4'd3) ||
          min2_o > 4'd5 || min1_o > 4'd9)
        bad_seen = 1'b1;
    end
  end

  function automatic logic [15:0] shown();
    return {hr2_o, hr1_o, min2_o, min1_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Each press is held for 3 edges and released for 3 edges. The task is
  // called at a negedge and returns at a negedge.
  task automatic press(input bit m, input bit h, input int n);
    for (int i = 0; i < n; i++) begin
      set_min_i = m;
      set_hr_i  = h;
      repeat (3) @(negedge clk_i);
      set_min_i = 1'b0;
      set_hr_i  = 1'b0;
      repeat (3) @(negedge clk_i);
    end
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    int budget;
    seen   = 0;
    budget = n * CLK_HZ + 20;
    while (seen < n && budget > 0) begin
      @(negedge clk_i);
      if (sec_tick_o) seen++;
      budget--;
    end
    chk("tick_count", seen, n);
  endtask

  initial begin
    rst_ni    = 1'b0;
    set_min_i = 1'b0;
    set_hr_i  = 1'b0;

    // Reset state, then the tick cadence and the refresh stepping after release.
    repeat (3) @(negedge clk_i);
    chk("rst_time", shown(), 16'h0000);
    chk("rst_odsw", odswiezanie_o, 2'b00);
    chk("rst_tick", sec_tick_o, 1'b0);
    rst_ni = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_i);
      chk("tick_cadence", sec_tick_o, (k % 4 == 0) ? 1 : 0);
      chk("odsw_step", odswiezanie_o, (k / 4) % 4);
    end

    // Plain counting from 00:00.
    do_reset();
    wait_ticks(60);
    chk("t60", shown(), 16'h0001);
    wait_ticks(540);
    chk("t600", shown(), 16'h0010);
    wait_ticks(3000);
    chk("t3600", shown(), 16'h0100);

    // Preload 23:59:59, then one tick rolls straight over to 00:00.
    do_reset();
    press(0, 1, 23);
    chk("pre_hr", shown(), 16'h2300);
    press(1, 0, 59);
    chk("pre_min", shown(), 16'h2359);
    wait_ticks(59);
    chk("pre_sec59", shown(), 16'h2359);
    wait_ticks(1);
    chk("rollover", shown(), 16'h0000);

    // A long hold of the minute button at 05:59 gives exactly one increment,
    // and the seconds count restarts from zero.
    do_reset();
    press(0, 1, 5);
    press(1, 0, 59);
    chk("hold_pre", shown(), 16'h0559);
    set_min_i = 1'b1;
    fork
      begin
        repeat (50) @(negedge clk_i);
        set_min_i = 1'b0;
      end
    join_none
    repeat (3) @(negedge clk_i);
    chk("hold_wrap", shown(), 16'h0500);
    wait_ticks(59);
    chk("hold_once", shown(), 16'h0500);
    wait_ticks(1);
    chk("hold_sec0", shown(), 16'h0501);
    press(0, 1, 18);
    chk("hr_to23", shown(), 16'h2301);
    press(0, 1, 1);
    chk("hr_wrap", shown(), 16'h0001);

    // The hour press lands in the cycle of the 10:59:59 tick.
    do_reset();
    press(0, 1, 10);
    press(1, 0, 58);
    set_min_i = 1'b1;
    repeat (3) @(negedge clk_i);
    set_min_i = 1'b0;
    chk("align_pre", shown(), 16'h1059);
    repeat (237) @(negedge clk_i);
    set_hr_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("hr_carry_once", shown(), 16'h1100);
    chk("hr_carry_tick", sec_tick_o, 1'b1);
    set_hr_i = 1'b0;
    // The minute press lands in the cycle of the 11:00:59 tick.
    repeat (237) @(negedge clk_i);
    set_min_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("min_carry_once", shown(), 16'h1101);
    chk("min_carry_tick", sec_tick_o, 1'b1);
    set_min_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Both buttons pressed together.
    press(1, 1, 1);
    chk("both", shown(), 16'h1202);

    // Asynchronous reset takes effect between clock edges.
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_time", shown(), 16'h0000);
    chk("arst_odsw", odswiezanie_o, 2'b00);
    chk("arst_tick", sec_tick_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    chk("range", bad_seen, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/licznik_czasu.md
# licznik_czasu

Real-time clock time-base and BCD time counter. Divides the system clock to a 1 Hz tick, keeps seconds internally and hours/minutes as four BCD digits, and accepts two push-button inputs for setting the time. Sits directly upstream of the 7-segment display multiplexer: drives its four digit inputs and its 2-bit digit-select (`odswiezanie`) input.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency; the prescaler divides by this value to produce the 1 Hz tick. Minimum 2.
- `REFRESH_BITS`, 18: width of the free-running display refresh counter; `odswiezanie_o` is its top 2 bits. Minimum 2.

- `clk_i`  in  1: system clock, all state on rising edge.
- `rst_ni`  in  1: asynchronous active-low reset.
- `set_min_i`  in  1: minute-set button, asynchronous, active-high level.
- `set_hr_i`  in  1: hour-set button, asynchronous, active-high level.
- `hr2_o`  out  4: hours tens, BCD 0..2.
- `hr1_o`  out  4: hours units, BCD 0..9 (0..3 when `hr2_o`=2).
- `min2_o`  out  4: minutes tens, BCD 0..5.
- `min1_o`  out  4: minutes units, BCD 0..9.
- `odswiezanie_o`  out  2: display digit select; 00 = `hr2`, 01 = `hr1`, 10 = `min2`, 11 = `min1`.
- `sec_tick_o`  out  1: one-cycle pulse, once per second.

## Operation
- Reset (`rst_ni`=0, immediate): prescaler, seconds, all digits, refresh counter and sync/edge flops cleared; all outputs 0, i.e. time 00:00:00, `odswiezanie_o`=00, `sec_tick_o`=0.
- Prescaler: counts 0..CLK_HZ-1, wraps to 0. Tick asserted in the cycle the count equals CLK_HZ-1.
- Seconds: 6-bit binary, 0..59. On tick: +1; at 59 wraps to 0 and generates minute carry.
- Minutes: on carry, `min1` +1; `min1` 9→0 increments `min2`; 59→00 generates hour carry.
- Hours: on carry or set, 23→00; otherwise `hr1` 9→0 increments `hr2`. Never leave 00..23.
- Buttons: each passes through a 2-flop synchroniser, then rising-edge detection against a third flop. One press = exactly one increment regardless of hold length; no auto-repeat; no debounce in this block (bounces produce extra increments).
- `set_min` edge: minutes +1 with wrap 59→00, **no** carry into hours; seconds and prescaler cleared to 0.
- `set_hr` edge: hours +1 with wrap 23→00; minutes/seconds unaffected.
- Refresh counter: free-running REFRESH_BITS-bit up-counter, wraps naturally; not affected by buttons.
- `sec_tick_o`: registered copy of the tick.

## Timing
- All outputs registered; no combinational input→output paths.
- Tick in cycle N: `sec_tick_o` high in cycle N+1; seconds/digits updated at the edge ending cycle N (digits visible in N+1).
- Button: input high before edge E1 → sync1 at E1, sync2 at E2, edge pulse between E2 and E3, digit change at E3 (3-edge latency). Must stay high ≥3 edges to register.
- Simultaneous events:
  - `set_min` edge + minute carry same cycle: set wins; minutes +1 once; seconds cleared; carry dropped.
  - `set_hr` edge + hour carry same cycle: hours +1 once (not +2); minutes still wrap 59→00.
  - Both buttons same cycle: both applied independently.
- Reset mid-operation: asynchronous assertion clears everything within the cycle; after deassertion, first tick occurs CLK_HZ cycles later.
- Period: `odswiezanie_o` advances every 2^(REFRESH_BITS-2) cycles.

## Test plan
- CLK_HZ=4: release reset → outputs 0; `sec_tick_o` first high in cycle 5 after release, then every 4 cycles.
- CLK_HZ=4, run 60 ticks from 00:00 → digits 0,0,0,1 (00:01) on the cycle after the 60th tick; 3600 ticks → 01:00.
- Preload 23:59:59 via buttons/ticks, one tick → 00:00, no glitch through 24:00.
- Hold `set_min_i` high 50 cycles at 00:59 → exactly 00:00, hours unchanged, seconds=0; `set_hr_i` at 23:xx → 00:xx.
- At seconds=59/minutes=59 align `set_hr` edge with tick → hours +1 exactly once, minutes 00.
- REFRESH_BITS=4: `odswiezanie_o` steps 00,01,10,11,00 every 4 cycles; assert `rst_ni` mid-count → all outputs 0 before next clock edge.
